hovalaag_io: RTL and testbench

HOVALAAG_IO -- requirements
Module: hovalaag_io

---
 rtl/hovalaag_io_pkg.sv | 10 +
 rtl/hovalaag.sv | 3 +
 rtl/hovalaag_fifo.sv | 52 +++++
 rtl/hovalaag_io.sv | 88 ++++++++
 tb/tb_hovalaag_io.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hovalaag_io_pkg.sv
// Shared constants and types for the HOVALAAG host/CPU I/O block.
package hovalaag_io_pkg;
    localparam int DATA_W        = 12;
    localparam int DEPTH_DEFAULT = 16;
    localparam int ERR_W         = 4;
    localparam int ERR_IN_OVF    = 0;
    localparam int ERR_OUT_UDF   = 1;

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/hovalaag.sv
// Empty module kept alongside the design; the top level is hovalaag_io in hovalaag_io.sv.
module hovalaag_unused_stub;
endmodule

// File: rtl/hovalaag_fifo.sv
// Show-ahead FIFO: head is valid combinationally whenever the FIFO is non-empty, 0 otherwise.
module hovalaag_fifo
    import hovalaag_io_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int LVL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  word_t            wdata,
    output word_t            head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    word_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push_ok = push & (~full | pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/hovalaag_io.sv
// Host/CPU I/O block: two input FIFOs fed by the host, two output FIFOs fed by the CPU, and CPU clock gating.
module hovalaag_io
    import hovalaag_io_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int LVL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             in1_wr,
    input  logic             in2_wr,
    input  word_t            in_wdata,
    output logic [LVL_W-1:0] in1_level,
    output logic [LVL_W-1:0] in2_level,
    input  logic             out1_rd,
    input  logic             out2_rd,
    output word_t            out1_rdata,
    output word_t            out2_rdata,
    output logic [LVL_W-1:0] out1_level,
    output logic [LVL_W-1:0] out2_level,
    output word_t            IN1,
    output word_t            IN2,
    input  logic             IN1_adv,
    input  logic             IN2_adv,
    input  word_t            OUT,
    input  logic             OUT_valid,
    input  logic             OUT_select,
    output logic             cpu_clk_en,
    output logic             stalled,
    output logic [15:0]      cycles,
    output logic [ERR_W-1:0] err
);
    logic in1_full, in1_empty, in2_full, in2_empty;
    logic out1_full, out1_empty, out2_full, out2_empty;
    logic in1_pop, in2_pop, out1_push, out2_push;
    logic out_blocked;
    logic [ERR_W-1:0] err_set;

    assign out_blocked = OUT_valid & (OUT_select ? out2_full : out1_full);
    assign cpu_clk_en  = rst_n & run
                       & ~(IN1_adv & in1_empty)
                       & ~(IN2_adv & in2_empty)
                       & ~out_blocked;
    assign stalled     = run & ~cpu_clk_en;

    // CPU-side transfers only happen on enabled edges, so a stalled instruction never repeats its side effects.
    assign in1_pop   = IN1_adv & cpu_clk_en;
    assign in2_pop   = IN2_adv & cpu_clk_en;
    assign out1_push = OUT_valid & cpu_clk_en & ~OUT_select;
    assign out2_push = OUT_valid & cpu_clk_en & OUT_select;

    always_comb begin
        err_set = '0;
        err_set[ERR_IN_OVF]  = (in1_wr & in1_full & ~in1_pop) | (in2_wr & in2_full & ~in2_pop);
        err_set[ERR_OUT_UDF] = (out1_rd & out1_empty) | (out2_rd & out2_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
            err    <= '0;
        end else begin
            if (cpu_clk_en) cycles <= cycles + 16'd1;
            err <= err | err_set;
        end
    end

    hovalaag_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_in1 (
        .clk(clk), .rst_n(rst_n), .push(in1_wr), .pop(in1_pop), .wdata(in_wdata),
        .head(IN1), .full(in1_full), .empty(in1_empty), .level(in1_level)
    );

    hovalaag_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_in2 (
        .clk(clk), .rst_n(rst_n), .push(in2_wr), .pop(in2_pop), .wdata(in_wdata),
        .head(IN2), .full(in2_full), .empty(in2_empty), .level(in2_level)
    );

    hovalaag_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_out1 (
        .clk(clk), .rst_n(rst_n), .push(out1_push), .pop(out1_rd), .wdata(OUT),
        .head(out1_rdata), .full(out1_full), .empty(out1_empty), .level(out1_level)
    );

    hovalaag_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_out2 (
        .clk(clk), .rst_n(rst_n), .push(out2_push), .pop(out2_rd), .wdata(OUT),
        .head(out2_rdata), .full(out2_full), .empty(out2_empty), .level(out2_level)
    );
endmodule

// File: tb/tb_hovalaag_io.sv
// Directed self-checking bench for hovalaag_io.
module tb_hovalaag_io;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        in1_wr, in2_wr;
    logic [11:0] in_wdata;
    logic [4:0]  in1_level, in2_level;
    logic        out1_rd, out2_rd;
    logic [11:0] out1_rdata, out2_rdata;
    logic [4:0]  out1_level, out2_level;
    logic [11:0] IN1, IN2;
    logic        IN1_adv, IN2_adv;
    logic [11:0] OUT;
    logic        OUT_valid, OUT_select;
    logic        cpu_clk_en;
    logic        stalled;
    logic [15:0] cycles;
    logic [3:0]  err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hovalaag_io #(.DEPTH(16), .LVL_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .in1_wr(in1_wr), .in2_wr(in2_wr), .in_wdata(in_wdata),
        .in1_level(in1_level), .in2_level(in2_level),
        .out1_rd(out1_rd), .out2_rd(out2_rd),
        .out1_rdata(out1_rdata), .out2_rdata(out2_rdata),
        .out1_level(out1_level), .out2_level(out2_level),
        .IN1(IN1), .IN2(IN2), .IN1_adv(IN1_adv), .IN2_adv(IN2_adv),
        .OUT(OUT), .OUT_valid(OUT_valid), .OUT_select(OUT_select),
        .cpu_clk_en(cpu_clk_en), .stalled(stalled), .cycles(cycles), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1;
        in1_wr = 0; in2_wr = 0; in_wdata = '0;
        out1_rd = 0; out2_rd = 0;
        IN1_adv = 0; IN2_adv = 0; OUT = '0; OUT_valid = 0; OUT_select = 0;
        #2;
        checks++; if (cpu_clk_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", cpu_clk_en); end
        tick(); tick();
        checks++; if (in1_level !== 5'd0) begin failures++; $display("FAIL reset_in1_level: got %0d expected 0", in1_level); end
        checks++; if (out2_level !== 5'd0) begin failures++; $display("FAIL reset_out2_level: got %0d expected 0", out2_level); end
        checks++; if (cycles !== 16'd0) begin failures++; $display("FAIL reset_cycles: got %0d expected 0", cycles); end
        checks++; if (err !== 4'd0) begin failures++; $display("FAIL reset_err: got %b expected 0000", err); end
        checks++; if (IN1 !== 12'd0) begin failures++; $display("FAIL reset_IN1: got %h expected 000", IN1); end
        checks++; if (out1_rdata !== 12'd0) begin failures++; $display("FAIL reset_out1_rdata: got %h expected 000", out1_rdata); end
        run = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_in_consume();
        logic [11:0] exp_words [3];
        exp_words[0] = 12'd5; exp_words[1] = 12'd6; exp_words[2] = 12'd7;
        for (int i = 0; i < 3; i++) begin
            in1_wr = 1; in_wdata = exp_words[i];
            tick();
        end
        in1_wr = 0;
        checks++; if (in1_level !== 5'd3) begin failures++; $display("FAIL in1_fill_level: got %0d expected 3", in1_level); end
        run = 1; IN1_adv = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (IN1 !== exp_words[i]) begin failures++; $display("FAIL in1_head_%0d: got %h expected %h", i, IN1, exp_words[i]); end
            checks++; if (cpu_clk_en !== 1'b1) begin failures++; $display("FAIL in1_en_%0d: got %b expected 1", i, cpu_clk_en); end
            tick();
        end
        #1;
        checks++; if (IN1 !== 12'd0) begin failures++; $display("FAIL in1_empty_head: got %h expected 000", IN1); end
        checks++; if (cpu_clk_en !== 1'b0) begin failures++; $display("FAIL in1_stall_en: got %b expected 0", cpu_clk_en); end
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL in1_stalled: got %b expected 1", stalled); end
        checks++; if (cycles !== 16'd3) begin failures++; $display("FAIL in1_cycles: got %0d expected 3", cycles); end
        tick();
        run = 0; IN1_adv = 0;
    endtask

    task automatic test_out_stall();
        OUT_valid = 1; OUT_select = 1; OUT = 12'h123; run = 0;
        for (int i = 0; i < 3; i++) tick();
        run = 1;
        tick();
        run = 0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (out2_level !== 5'd1) begin failures++; $display("FAIL stall_out2_level: got %0d expected 1", out2_level); end
        checks++; if (out2_rdata !== 12'h123) begin failures++; $display("FAIL stall_out2_rdata: got %h expected 123", out2_rdata); end
        checks++; if (out1_level !== 5'd0) begin failures++; $display("FAIL stall_out1_level: got %0d expected 0", out1_level); end
        checks++; if (cycles !== 16'd4) begin failures++; $display("FAIL stall_cycles: got %0d expected 4", cycles); end
        OUT_valid = 0; OUT_select = 0;
        out2_rd = 1;
        tick();
        out2_rd = 0;
        checks++; if (out2_level !== 5'd0) begin failures++; $display("FAIL stall_out2_drain: got %0d expected 0", out2_level); end
    endtask

    task automatic test_out_full();
        logic [11:0] exp;
        run = 1; OUT_valid = 1; OUT_select = 0;
        for (int i = 0; i < 16; i++) begin
            OUT = 12'h200 + 12'(i);
            tick();
        end
        OUT = 12'h0AA;
        #1;
        checks++; if (out1_level !== 5'd16) begin failures++; $display("FAIL full_level: got %0d expected 16", out1_level); end
        checks++; if (cpu_clk_en !== 1'b0) begin failures++; $display("FAIL full_en: got %b expected 0", cpu_clk_en); end
        checks++; if (out1_rdata !== 12'h200) begin failures++; $display("FAIL full_head: got %h expected 200", out1_rdata); end
        out1_rd = 1;
        tick();
        out1_rd = 0;
        #1;
        checks++; if (out1_level !== 5'd15) begin failures++; $display("FAIL full_after_pop: got %0d expected 15", out1_level); end
        checks++; if (cpu_clk_en !== 1'b1) begin failures++; $display("FAIL full_en_resume: got %b expected 1", cpu_clk_en); end
        tick();
        run = 0; OUT_valid = 0;
        checks++; if (out1_level !== 5'd16) begin failures++; $display("FAIL full_refill: got %0d expected 16", out1_level); end
        checks++; if (cycles !== 16'd21) begin failures++; $display("FAIL full_cycles: got %0d expected 21", cycles); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 12'h201 + 12'(i) : 12'h0AA;
            checks++; if (out1_rdata !== exp) begin failures++; $display("FAIL full_order_%0d: got %h expected %h", i, out1_rdata, exp); end
            out1_rd = 1;
            tick();
        end
        out1_rd = 0;
        checks++; if (out1_level !== 5'd0) begin failures++; $display("FAIL full_drained: got %0d expected 0", out1_level); end
    endtask

    task automatic test_simul_push_pop();
        in1_wr = 1; in_wdata = 12'h010; tick();
        in_wdata = 12'h020; tick();
        in_wdata = 12'h030; run = 1; IN1_adv = 1;
        tick();
        in1_wr = 0;
        checks++; if (in1_level !== 5'd2) begin failures++; $display("FAIL simul_level: got %0d expected 2", in1_level); end
        checks++; if (IN1 !== 12'h020) begin failures++; $display("FAIL simul_head0: got %h expected 020", IN1); end
        tick();
        checks++; if (IN1 !== 12'h030) begin failures++; $display("FAIL simul_head1: got %h expected 030", IN1); end
        tick();
        run = 0; IN1_adv = 0;
        checks++; if (in1_level !== 5'd0) begin failures++; $display("FAIL simul_drain: got %0d expected 0", in1_level); end
        checks++; if (cycles !== 16'd24) begin failures++; $display("FAIL simul_cycles: got %0d expected 24", cycles); end
    endtask

    task automatic test_overflow();
        logic [11:0] exp;
        checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL ovf_pre_err: got %b expected 0", err[0]); end
        in2_wr = 1;
        for (int i = 0; i < 17; i++) begin
            in_wdata = 12'h100 + 12'(i);
            tick();
        end
        in2_wr = 0;
        checks++; if (in2_level !== 5'd16) begin failures++; $display("FAIL ovf_level: got %0d expected 16", in2_level); end
        checks++; if (err[0] !== 1'b1) begin failures++; $display("FAIL ovf_err: got %b expected 1", err[0]); end
        checks++; if (IN2 !== 12'h100) begin failures++; $display("FAIL ovf_head: got %h expected 100", IN2); end
        in2_wr = 1; in_wdata = 12'h7FF; run = 1; IN2_adv = 1;
        tick();
        in2_wr = 0;
        checks++; if (in2_level !== 5'd16) begin failures++; $display("FAIL ovf_full_pushpop: got %0d expected 16", in2_level); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 12'h101 + 12'(i) : 12'h7FF;
            checks++; if (IN2 !== exp) begin failures++; $display("FAIL ovf_order_%0d: got %h expected %h", i, IN2, exp); end
            tick();
        end
        run = 0; IN2_adv = 0;
        checks++; if (in2_level !== 5'd0) begin failures++; $display("FAIL ovf_drained: got %0d expected 0", in2_level); end
        checks++; if (cycles !== 16'd41) begin failures++; $display("FAIL ovf_cycles: got %0d expected 41", cycles); end
    endtask

    task automatic test_underflow_reset();
        checks++; if (err[1] !== 1'b0) begin failures++; $display("FAIL udf_pre_err: got %b expected 0", err[1]); end
        out1_rd = 1;
        tick();
        out1_rd = 0;
        checks++; if (err !== 4'b0011) begin failures++; $display("FAIL udf_err: got %b expected 0011", err); end
        checks++; if (out1_level !== 5'd0) begin failures++; $display("FAIL udf_level: got %0d expected 0", out1_level); end
        run = 1; OUT_valid = 1; OUT_select = 1; OUT = 12'h055; out2_rd = 1;
        tick();
        out2_rd = 0; OUT_valid = 0;
        checks++; if (out2_level !== 5'd1) begin failures++; $display("FAIL udf_pushpop_level: got %0d expected 1", out2_level); end
        checks++; if (out2_rdata !== 12'h055) begin failures++; $display("FAIL udf_pushpop_data: got %h expected 055", out2_rdata); end
        in1_wr = 1; in_wdata = 12'h111;
        tick();
        in1_wr = 0;
        #2;
        rst_n = 0;
        #1;
        checks++; if (in1_level !== 5'd0) begin failures++; $display("FAIL arst_in1_level: got %0d expected 0", in1_level); end
        checks++; if (out2_level !== 5'd0) begin failures++; $display("FAIL arst_out2_level: got %0d expected 0", out2_level); end
        checks++; if (err !== 4'd0) begin failures++; $display("FAIL arst_err: got %b expected 0000", err); end
        checks++; if (cycles !== 16'd0) begin failures++; $display("FAIL arst_cycles: got %0d expected 0", cycles); end
        checks++; if (IN1 !== 12'd0) begin failures++; $display("FAIL arst_IN1: got %h expected 000", IN1); end
        checks++; if (out2_rdata !== 12'd0) begin failures++; $display("FAIL arst_out2_rdata: got %h expected 000", out2_rdata); end
        checks++; if (cpu_clk_en !== 1'b0) begin failures++; $display("FAIL arst_en: got %b expected 0", cpu_clk_en); end
        tick();
        run = 0;
        rst_n = 1;
        in1_wr = 1; in_wdata = 12'h3AB;
        tick();
        in1_wr = 0;
        checks++; if (in1_level !== 5'd1) begin failures++; $display("FAIL post_rst_level: got %0d expected 1", in1_level); end
        checks++; if (IN1 !== 12'h3AB) begin failures++; $display("FAIL post_rst_head: got %h expected 3ab", IN1); end
    endtask

    initial begin
        test_reset();
        test_in_consume();
        test_out_stall();
        test_out_full();
        test_simul_push_pop();
        test_overflow();
        test_underflow_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
